route_balancer: RTL and testbench

- Output-selection scheduler for the packet switch: for each packet address, picks one output port out of the set allowed by a per-destination route mask.
- Load-balances round-robin across the allowed outputs, per destination.
- Only picks outputs that hold a downstream credit; tracks per-output credits returned by the downstream buffers.
- Sits between the switch's input arbiter and its output demux, and drives the demux select through a one-entry registered decision stage.

---
 rtl/route_balancer_if.sv | 31 +++
 rtl/route_balancer.sv | 134 +++++++++++++
 tb/tb_route_balancer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/route_balancer_if.sv
// Request/decision/credit bundle between the input arbiter, the route balancer
// and the switch output demux.
interface route_balancer_if #(
    parameter int NumOut     = 4,
    parameter int NumDst     = 4,
    parameter int MaxCredits = 8,
    parameter int AddrW      = $clog2(NumDst),
    parameter int SelW       = $clog2(NumOut),
    parameter int CntW       = $clog2(MaxCredits + 1)
);
    logic                   req_valid_i;
    logic [AddrW-1:0]       req_addr_i;
    logic                   req_ready_o;
    logic                   sel_valid_o;
    logic [SelW-1:0]        sel_o;
    logic                   sel_ready_i;
    logic [NumOut-1:0]      credit_return_i;
    logic [NumOut*CntW-1:0] credit_o;
    logic                   drop_o;
    logic                   err_o;

    modport master (
        output req_valid_i, req_addr_i, sel_ready_i, credit_return_i,
        input  req_ready_o, sel_valid_o, sel_o, credit_o, drop_o, err_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, sel_ready_i, credit_return_i,
        output req_ready_o, sel_valid_o, sel_o, credit_o, drop_o, err_o
    );
endinterface

// File: rtl/route_balancer.sv
// Per-destination round-robin output selection restricted to routed outputs
// holding downstream credit; decision is presented from a one-entry register.
module route_balancer #(
    parameter int NumOut     = 4,
    parameter int NumDst     = 4,
    parameter int MaxCredits = 8,
    parameter int AddrW      = $clog2(NumDst),
    parameter int SelW       = $clog2(NumOut),
    parameter int CntW       = $clog2(MaxCredits + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumDst*NumOut-1:0] route_mask_i,
    route_balancer_if.slave          bus
);
    logic              sel_valid_q, sel_valid_d;
    logic [SelW-1:0]   sel_q, sel_d;
    logic              drop_q, drop_d;
    logic              err_q, err_d;
    logic [CntW-1:0]   credit_q [NumOut];
    logic [CntW-1:0]   credit_d [NumOut];
    logic [SelW-1:0]   rr_q [NumDst];
    logic [SelW-1:0]   rr_d [NumDst];

    logic [NumOut-1:0] mask_eff;
    logic [NumOut-1:0] eligible;
    logic [SelW-1:0]   rr_cur;
    logic [SelW-1:0]   chosen;
    logic              found;
    logic              free;
    logic              any_elig;
    logic              no_route;
    logic              capture;
    logic              drop;
    logic              overflow;
    int                idx;

    // Out-of-range addresses match no destination and so see an empty mask.
    always_comb begin
        mask_eff = '0;
        rr_cur   = '0;
        for (int d = 0; d < NumDst; d++) begin
            if (bus.req_addr_i == AddrW'(d)) begin
                mask_eff = route_mask_i[d*NumOut +: NumOut];
                rr_cur   = rr_q[d];
            end
        end
        for (int j = 0; j < NumOut; j++) begin
            eligible[j] = mask_eff[j] && (credit_q[j] != '0);
        end
    end

    // Search upward starting one past the last pick, wrapping modulo NumOut.
    always_comb begin
        found  = 1'b0;
        chosen = '0;
        idx    = 0;
        for (int k = 1; k <= NumOut; k++) begin
            idx = (int'(rr_cur) + k) % NumOut;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                chosen = SelW'(idx);
            end
        end
    end

    assign free            = !sel_valid_q || bus.sel_ready_i;
    assign any_elig        = |eligible;
    assign no_route        = (mask_eff == '0);
    assign bus.req_ready_o = free && (any_elig || no_route);
    assign capture         = bus.req_valid_i && bus.req_ready_o && any_elig;
    assign drop            = bus.req_valid_i && bus.req_ready_o && no_route;

    always_comb begin
        sel_valid_d = sel_valid_q;
        sel_d       = sel_q;
        drop_d      = drop;
        rr_d        = rr_q;
        credit_d    = credit_q;
        overflow    = 1'b0;

        if (capture) begin
            sel_valid_d = 1'b1;
            sel_d       = chosen;
            for (int d = 0; d < NumDst; d++) begin
                if (bus.req_addr_i == AddrW'(d)) rr_d[d] = chosen;
            end
        end else if (bus.sel_ready_i) begin
            sel_valid_d = 1'b0;
        end

        // A return that would exceed the buffer depth is a downstream bug: hold and flag.
        for (int j = 0; j < NumOut; j++) begin
            if (capture && (chosen == SelW'(j)) && !bus.credit_return_i[j]) begin
                credit_d[j] = credit_q[j] - CntW'(1);
            end else if (!(capture && (chosen == SelW'(j))) && bus.credit_return_i[j]) begin
                if (credit_q[j] == CntW'(MaxCredits)) begin
                    overflow = 1'b1;
                end else begin
                    credit_d[j] = credit_q[j] + CntW'(1);
                end
            end
        end

        err_d = err_q || drop || overflow;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_valid_q <= 1'b0;
            sel_q       <= '0;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int j = 0; j < NumOut; j++) credit_q[j] <= CntW'(MaxCredits);
            for (int d = 0; d < NumDst; d++) rr_q[d] <= SelW'(NumOut - 1);
        end else begin
            sel_valid_q <= sel_valid_d;
            sel_q       <= sel_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
            credit_q    <= credit_d;
            rr_q        <= rr_d;
        end
    end

    assign bus.sel_valid_o = sel_valid_q;
    assign bus.sel_o       = sel_q;
    assign bus.drop_o      = drop_q;
    assign bus.err_o       = err_q;

    for (genvar g = 0; g < NumOut; g++) begin : g_credit
        assign bus.credit_o[g*CntW +: CntW] = credit_q[g];
    end
endmodule

// File: tb/tb_route_balancer.sv
// Directed scenario bench for route_balancer with default parameters (4 outputs,
// 4 destinations, 8 credits).
module tb_route_balancer;
    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] mask;
    int          checks = 0;
    int          errors = 0;

    route_balancer_if bus ();

    route_balancer dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .route_mask_i(mask),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic int cr(input int j);
        return int'(bus.credit_o[j*CW +: CW]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                 = 1'b1;
        bus.req_valid_i     = 1'b0;
        bus.req_addr_i      = '0;
        bus.sel_ready_i     = 1'b1;
        bus.credit_return_i = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.sel_valid_o !== 1'b0) begin errors++; $display("FAIL reset_sel_valid: got %0b expected 0", bus.sel_valid_o); end
        checks++; if (bus.sel_o !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", bus.sel_o); end
        checks++; if (bus.drop_o !== 1'b0) begin errors++; $display("FAIL reset_drop: got %0b expected 0", bus.drop_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", bus.err_o); end
        for (int j = 0; j < 4; j++) begin
            checks++; if (cr(j) !== 8) begin errors++; $display("FAIL reset_credit%0d: got %0d expected 8", j, cr(j)); end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 2'd0;
        #1;
        checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL rr_ready: got %0b expected 1", bus.req_ready_o); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.sel_valid_o !== 1'b1) begin errors++; $display("FAIL rr_valid%0d: got %0b expected 1", i, bus.sel_valid_o); end
            checks++; if (int'(bus.sel_o) !== i % 4) begin errors++; $display("FAIL rr_sel%0d: got %0d expected %0d", i, bus.sel_o, i % 4); end
        end
        for (int j = 0; j < 4; j++) begin
            checks++; if (cr(j) !== ((j == 0) ? 6 : 7)) begin errors++; $display("FAIL rr_credit%0d: got %0d expected %0d", j, cr(j), (j == 0) ? 6 : 7); end
        end
        bus.req_valid_i = 1'b0;
        tick();
        checks++; if (bus.sel_valid_o !== 1'b0) begin errors++; $display("FAIL rr_drain_valid: got %0b expected 0", bus.sel_valid_o); end
        checks++; if (bus.sel_o !== 2'd0) begin errors++; $display("FAIL rr_drain_sel: got %0d expected 0", bus.sel_o); end
    endtask

    task automatic test_credit_exhaust();
        do_reset();
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 2'd1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (bus.sel_valid_o !== 1'b1 || bus.sel_o !== 2'd0) begin errors++; $display("FAIL exh_cap%0d: got v=%0b s=%0d expected v=1 s=0", i, bus.sel_valid_o, bus.sel_o); end
        end
        #1;
        checks++; if (cr(0) !== 0) begin errors++; $display("FAIL exh_credit0: got %0d expected 0", cr(0)); end
        checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL exh_ready: got %0b expected 0", bus.req_ready_o); end
        tick();
        checks++; if (bus.sel_valid_o !== 1'b0) begin errors++; $display("FAIL exh_stall_valid: got %0b expected 0", bus.sel_valid_o); end
        bus.credit_return_i = 4'b0001;
        tick();
        bus.credit_return_i = 4'b0000;
        #1;
        checks++; if (cr(0) !== 1) begin errors++; $display("FAIL exh_return: got %0d expected 1", cr(0)); end
        checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL exh_ready_again: got %0b expected 1", bus.req_ready_o); end
        tick();
        checks++; if (bus.sel_valid_o !== 1'b1 || bus.sel_o !== 2'd0) begin errors++; $display("FAIL exh_recap: got v=%0b s=%0d expected v=1 s=0", bus.sel_valid_o, bus.sel_o); end
        checks++; if (cr(0) !== 0) begin errors++; $display("FAIL exh_recap_credit: got %0d expected 0", cr(0)); end
        bus.req_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        do_reset();
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 2'd0;
        tick();
        tick();
        tick();
        checks++; if (bus.sel_o !== 2'd2) begin errors++; $display("FAIL hold_first: got %0d expected 2", bus.sel_o); end
        bus.sel_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.sel_valid_o !== 1'b1 || bus.sel_o !== 2'd2) begin errors++; $display("FAIL hold_stable%0d: got v=%0b s=%0d expected v=1 s=2", i, bus.sel_valid_o, bus.sel_o); end
            checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL hold_ready%0d: got %0b expected 0", i, bus.req_ready_o); end
        end
        bus.sel_ready_i = 1'b1;
        #1;
        checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %0b expected 1", bus.req_ready_o); end
        tick();
        checks++; if (bus.sel_valid_o !== 1'b1 || bus.sel_o !== 2'd3) begin errors++; $display("FAIL hold_no_bubble: got v=%0b s=%0d expected v=1 s=3", bus.sel_valid_o, bus.sel_o); end
        bus.req_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_mask_credit();
        do_reset();
        mask            = 16'h0A8F;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 2'd1;
        for (int i = 0; i < 8; i++) tick();
        checks++; if (cr(3) !== 0) begin errors++; $display("FAIL mc_drain3: got %0d expected 0", cr(3)); end
        mask           = 16'h0A1F;
        bus.req_addr_i = 2'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.sel_o !== 2'd1) begin errors++; $display("FAIL mc_only1_%0d: got %0d expected 1", i, bus.sel_o); end
        end
        bus.req_valid_i     = 1'b0;
        bus.credit_return_i = 4'b1000;
        tick();
        bus.credit_return_i = 4'b0000;
        checks++; if (cr(3) !== 1) begin errors++; $display("FAIL mc_return3: got %0d expected 1", cr(3)); end
        bus.req_valid_i = 1'b1;
        tick();
        checks++; if (bus.sel_o !== 2'd3) begin errors++; $display("FAIL mc_pick3: got %0d expected 3", bus.sel_o); end
        tick();
        checks++; if (bus.sel_o !== 2'd1) begin errors++; $display("FAIL mc_pick1: got %0d expected 1", bus.sel_o); end
        checks++; if (cr(1) !== 4 || cr(3) !== 0) begin errors++; $display("FAIL mc_credits: got c1=%0d c3=%0d expected c1=4 c3=0", cr(1), cr(3)); end
        bus.req_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_same_cycle();
        do_reset();
        bus.req_valid_i     = 1'b1;
        bus.req_addr_i      = 2'd2;
        bus.credit_return_i = 4'b0010;
        tick();
        bus.req_valid_i     = 1'b0;
        bus.credit_return_i = 4'b0001;
        checks++; if (bus.sel_valid_o !== 1'b1 || bus.sel_o !== 2'd1) begin errors++; $display("FAIL sc_pick: got v=%0b s=%0d expected v=1 s=1", bus.sel_valid_o, bus.sel_o); end
        checks++; if (cr(1) !== 8) begin errors++; $display("FAIL sc_credit1: got %0d expected 8", cr(1)); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL sc_no_err: got %0b expected 0", bus.err_o); end
        tick();
        bus.credit_return_i = 4'b0000;
        checks++; if (cr(0) !== 8) begin errors++; $display("FAIL sc_over_credit0: got %0d expected 8", cr(0)); end
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL sc_over_err: got %0b expected 1", bus.err_o); end
        tick();
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL sc_err_sticky: got %0b expected 1", bus.err_o); end
    endtask

    task automatic test_drop_and_reset();
        do_reset();
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 2'd3;
        #1;
        checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL drop_ready: got %0b expected 1", bus.req_ready_o); end
        tick();
        bus.req_valid_i = 1'b0;
        checks++; if (bus.drop_o !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %0b expected 1", bus.drop_o); end
        checks++; if (bus.sel_valid_o !== 1'b0) begin errors++; $display("FAIL drop_no_sel: got %0b expected 0", bus.sel_valid_o); end
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL drop_err: got %0b expected 1", bus.err_o); end
        for (int j = 0; j < 4; j++) begin
            checks++; if (cr(j) !== 8) begin errors++; $display("FAIL drop_credit%0d: got %0d expected 8", j, cr(j)); end
        end
        tick();
        checks++; if (bus.drop_o !== 1'b0 || bus.err_o !== 1'b1) begin errors++; $display("FAIL drop_after: got drop=%0b err=%0b expected drop=0 err=1", bus.drop_o, bus.err_o); end
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 2'd0;
        bus.sel_ready_i = 1'b0;
        tick();
        tick();
        checks++; if (bus.sel_valid_o !== 1'b1 || bus.sel_o !== 2'd0 || cr(0) !== 7) begin errors++; $display("FAIL midhold_setup: got v=%0b s=%0d c0=%0d expected v=1 s=0 c0=7", bus.sel_valid_o, bus.sel_o, cr(0)); end
        rst             = 1'b1;
        bus.req_valid_i = 1'b0;
        tick();
        rst = 1'b0;
        checks++; if (bus.sel_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b expected 0", bus.sel_valid_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL midrst_err: got %0b expected 0", bus.err_o); end
        for (int j = 0; j < 4; j++) begin
            checks++; if (cr(j) !== 8) begin errors++; $display("FAIL midrst_credit%0d: got %0d expected 8", j, cr(j)); end
        end
    endtask

    initial begin
        mask                = 16'h0A1F;
        bus.req_valid_i     = 1'b0;
        bus.req_addr_i      = '0;
        bus.sel_ready_i     = 1'b1;
        bus.credit_return_i = '0;
        test_reset();
        test_round_robin();
        test_credit_exhaust();
        test_hold();
        test_mask_credit();
        test_same_cycle();
        test_drop_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
